// File: rtl/color_map_checker.sv
// Read-only audit of a four-colour map held in a shared 256x8 memory.
// Walks the index table and adjacency list and counts adjacent regions that share a colour.
module color_map_checker #(
    parameter int NUM_REGIONS = 33,
    parameter int ADJ_BASE    = 0,
    parameter int IDX_BASE    = 148,
    parameter int COLOR_BASE  = 181,
    parameter int END_ADDR    = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rdata,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic       fault,
    output logic [7:0] conflicts,
    output logic [7:0] err_region,
    output logic [7:0] err_neighbor
);

    localparam logic [7:0] LP_N     = 8'(NUM_REGIONS);
    localparam logic [7:0] LP_LAST  = 8'(NUM_REGIONS - 1);
    localparam logic [7:0] LP_ADJ   = 8'(ADJ_BASE);
    localparam logic [7:0] LP_IDX   = 8'(IDX_BASE);
    localparam logic [7:0] LP_COLOR = 8'(COLOR_BASE);
    localparam logic [7:0] LP_END   = 8'(END_ADDR);

    typedef enum logic [2:0] {
        S_IDLE, S_IDX, S_END, S_CR, S_NB, S_CN, S_DONE
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [7:0] r_addr, w_addr_nxt;
    logic [7:0] r_region, w_region_nxt;
    logic [8:0] r_ptr, w_ptr_nxt;
    logic [8:0] r_end, w_end_nxt;
    logic [7:0] r_cr, w_cr_nxt;
    logic [7:0] r_nb, w_nb_nxt;
    logic [7:0] r_conflicts, w_conflicts_nxt;
    logic [7:0] r_err_region, w_err_region_nxt;
    logic [7:0] r_err_neighbor, w_err_neighbor_nxt;
    logic       r_fault, w_fault_nxt;
    logic       r_pass, w_pass_nxt;
    logic [8:0] w_ptr_inc;
    logic       w_advance;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_addr         <= '0;
            r_region       <= '0;
            r_ptr          <= '0;
            r_end          <= '0;
            r_cr           <= '0;
            r_nb           <= '0;
            r_conflicts    <= '0;
            r_err_region   <= '0;
            r_err_neighbor <= '0;
            r_fault        <= 1'b0;
            r_pass         <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            r_state        <= w_state_nxt;
            r_addr         <= w_addr_nxt;
            r_region       <= w_region_nxt;
            r_ptr          <= w_ptr_nxt;
            r_end          <= w_end_nxt;
            r_cr           <= w_cr_nxt;
            r_nb           <= w_nb_nxt;
            r_conflicts    <= w_conflicts_nxt;
            r_err_region   <= w_err_region_nxt;
            r_err_neighbor <= w_err_neighbor_nxt;
            r_fault        <= w_fault_nxt;
            r_pass         <= w_pass_nxt;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        w_state_nxt        = r_state;
        w_addr_nxt         = r_addr;
        w_region_nxt       = r_region;
        w_ptr_nxt          = r_ptr;
        w_end_nxt          = r_end;
        w_cr_nxt           = r_cr;
        w_nb_nxt           = r_nb;
        w_conflicts_nxt    = r_conflicts;
        w_err_region_nxt   = r_err_region;
        w_err_neighbor_nxt = r_err_neighbor;
        w_fault_nxt        = r_fault;
        w_pass_nxt         = r_pass;
        w_ptr_inc          = r_ptr + 9'd1;
        w_advance          = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_conflicts_nxt    = '0;
                    w_err_region_nxt   = '0;
                    w_err_neighbor_nxt = '0;
                    w_fault_nxt        = 1'b0;
                    w_pass_nxt         = 1'b0;
                    w_region_nxt       = '0;
                    w_addr_nxt         = LP_IDX;
                    w_state_nxt        = S_IDX;
                end
            end
            S_IDX: begin
                w_ptr_nxt   = {1'b0, mem_rdata};
                w_addr_nxt  = (r_region < LP_LAST) ? (LP_IDX + r_region + 8'd1) : LP_END;
                w_state_nxt = S_END;
            end
            S_END: begin
                // The last region's bound is inclusive, so it may reach 256.
                w_end_nxt   = (r_region < LP_LAST) ? {1'b0, mem_rdata}
                                                   : ({1'b0, mem_rdata} + 9'd1);
                w_addr_nxt  = LP_COLOR + r_region;
                w_state_nxt = S_CR;
            end
            S_CR: begin
                w_cr_nxt = mem_rdata;
                if (r_ptr == r_end) begin
                    w_advance = 1'b1;
                end else begin
                    w_addr_nxt  = LP_ADJ + r_ptr[7:0];
                    w_state_nxt = S_NB;
                end
            end
            S_NB: begin
                w_nb_nxt = mem_rdata;
                if (mem_rdata >= LP_N) begin
                    w_fault_nxt = 1'b1;
                end
                w_addr_nxt  = LP_COLOR + mem_rdata;
                w_state_nxt = S_CN;
            end
            S_CN: begin
                if ((r_nb < LP_N) && (mem_rdata == r_cr)) begin
                    if (r_conflicts == 8'd0) begin
                        w_err_region_nxt   = r_region;
                        w_err_neighbor_nxt = r_nb;
                    end
                    if (r_conflicts != 8'hFF) begin
                        w_conflicts_nxt = r_conflicts + 8'd1;
                    end
                end
                w_ptr_nxt = w_ptr_inc;
                if (w_ptr_inc == r_end) begin
                    w_advance = 1'b1;
                end else begin
                    w_addr_nxt  = LP_ADJ + w_ptr_inc[7:0];
                    w_state_nxt = S_NB;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Pass is decided on entry to DONE so it is already valid while done is high.
        if (w_advance) begin
            if (r_region == LP_LAST) begin
                w_state_nxt = S_DONE;
                w_addr_nxt  = '0;
                w_pass_nxt  = (w_conflicts_nxt == 8'd0) && !w_fault_nxt;
            end else begin
                w_region_nxt = r_region + 8'd1;
                w_addr_nxt   = LP_IDX + r_region + 8'd1;
                w_state_nxt  = S_IDX;
            end
        end
    end

    assign mem_addr     = r_addr;
    assign busy         = (r_state != S_IDLE);
    assign done         = (r_state == S_DONE);
    assign pass         = r_pass;
    assign fault        = r_fault;
    assign conflicts    = r_conflicts;
    assign err_region   = r_err_region;
    assign err_neighbor = r_err_neighbor;

endmodule

// File: tb/tb_color_map_checker.sv
// Scoreboard bench for color_map_checker: a behavioural map walker predicts each scan,
// and a monitor compares the result whenever done pulses.
module tb_color_map_checker;

    localparam int N     = 33;
    localparam int ADJ   = 0;
    localparam int IDX   = 148;
    localparam int COLOR = 181;
    localparam int ENDA  = 255;

    typedef struct {
        int conflicts;
        int err_r;
        int err_n;
        int fault;
        int pass;
        int lat;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] mem_addr;
    logic [7:0] mem_rdata;
    logic       busy;
    logic       done;
    logic       pass;
    logic       fault;
    logic [7:0] conflicts;
    logic [7:0] err_region;
    logic [7:0] err_neighbor;

    logic [7:0] mem [0:255];
    exp_t       sb_q[$];
    int         n_checks;
    int         n_fail;

    assign mem_rdata = mem[mem_addr];

    color_map_checker dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .fault        (fault),
        .conflicts    (conflicts),
        .err_region   (err_region),
        .err_neighbor (err_neighbor)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Map: edges r-(r+1), r-(r+2) for all r, and r-(r+3) for r<=10: 74 edges, 148 entries.
    task automatic build_map();
        int   off;
        logic adj [0:N-1][0:N-1];
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                adj[i][j] = 1'b0;
        for (int r = 0; r < N; r++)
            for (int d = 1; d <= 3; d++)
                if ((r + d < N) && (d < 3 || r <= 10)) begin
                    adj[r][r+d] = 1'b1;
                    adj[r+d][r] = 1'b1;
                end
        off = 0;
        for (int r = 0; r < N; r++) begin
            mem[IDX+r] = 8'(off);
            for (int s = 0; s < N; s++)
                if (adj[r][s]) begin
                    mem[ADJ+off] = 8'(s);
                    off++;
                end
        end
        mem[ENDA] = 8'(off - 1);
    endtask

    // mode 0: all zero, 1: r mod 4 (valid for this map), 2: random
    task automatic set_colors(input int mode);
        for (int r = 0; r < N; r++) begin
            if (mode == 0)      mem[COLOR+r] = 8'd0;
            else if (mode == 1) mem[COLOR+r] = 8'(r % 4);
            else                mem[COLOR+r] = 8'($urandom_range(0, 3));
        end
    endtask

    function automatic exp_t model();
        exp_t e;
        int   cyc;
        int   nconf;
        int   first;
        int   last_ex;
        int   nb;
        e.fault = 0;
        e.err_r = 0;
        e.err_n = 0;
        nconf   = 0;
        cyc     = 0;
        for (int r = 0; r < N; r++) begin
            first   = int'(mem[IDX+r]);
            last_ex = (r < N - 1) ? int'(mem[IDX+r+1]) : int'(mem[ENDA]) + 1;
            cyc += 3;
            for (int p = first; p != last_ex; p = (p + 1) % 512) begin
                nb = int'(mem[(ADJ + p) % 256]);
                cyc += 2;
                if (nb >= N) begin
                    e.fault = 1;
                end else if (mem[COLOR+nb] == mem[COLOR+r]) begin
                    if (nconf == 0) begin
                        e.err_r = r;
                        e.err_n = nb;
                    end
                    nconf++;
                end
            end
        end
        e.conflicts = (nconf > 255) ? 255 : nconf;
        e.pass      = (nconf == 0 && e.fault == 0) ? 1 : 0;
        e.lat       = cyc + 1;
        return e;
    endfunction

    initial begin : monitor
        int   busy_cnt;
        exp_t e;
        busy_cnt = 0;
        forever begin
            @(negedge clk);
            if (busy) busy_cnt++;
            else      busy_cnt = 0;
            if (done) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 expected no scan at %0t", $time);
                end else begin
                    e = sb_q.pop_front();
                    check("conflicts",    int'(conflicts),    e.conflicts);
                    check("err_region",   int'(err_region),   e.err_r);
                    check("err_neighbor", int'(err_neighbor), e.err_n);
                    check("fault",        int'(fault),        e.fault);
                    check("pass",         int'(pass),         e.pass);
                    check("latency",      busy_cnt,           e.lat);
                end
            end
        end
    end

    task automatic wait_empty();
        int i;
        i = 0;
        while (sb_q.size() != 0 && i < 2000) begin
            @(negedge clk);
            i++;
        end
        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scan_timeout: got %0d pending scans expected 0", sb_q.size());
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    // poke > 0 re-pulses start roughly poke cycles into the scan; it must be ignored.
    task automatic run_scan(input int poke);
        sb_q.push_back(model());
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (poke > 0) begin
            repeat (poke - 1) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_empty();
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        exp_t e;
        int   i;
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        for (int a = 0; a < 256; a++) mem[a] = 8'd0;
        build_map();
        set_colors(0);

        repeat (3) @(negedge clk);
        check("rst_busy",         int'(busy),         0);
        check("rst_done",         int'(done),         0);
        check("rst_pass",         int'(pass),         0);
        check("rst_fault",        int'(fault),        0);
        check("rst_mem_addr",     int'(mem_addr),     0);
        check("rst_conflicts",    int'(conflicts),    0);
        check("rst_err_region",   int'(err_region),   0);
        check("rst_err_neighbor", int'(err_neighbor), 0);
        rst = 1'b0;
        @(negedge clk);

        // All colours zero: every entry conflicts.
        run_scan(0);

        // Valid colouring; pass must hold after done.
        set_colors(1);
        e = model();
        run_scan(0);
        check("pass_hold_idle", int'(pass), e.pass);
        check("busy_idle",      int'(busy), 0);

        // Adjacent regions 1 and 3 share a colour.
        mem[COLOR+3] = mem[COLOR+1];
        run_scan(0);

        // Out-of-range neighbour number.
        set_colors(1);
        mem[ADJ+2] = 8'd40;
        run_scan(0);

        // Region 5 empty.
        build_map();
        mem[IDX+5] = mem[IDX+6];
        run_scan(0);

        // Start pulse mid-scan is ignored.
        build_map();
        run_scan(100);

        // Reset mid-scan aborts at once.
        set_colors(0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (200) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy",      int'(busy),      0);
        check("abort_mem_addr",  int'(mem_addr),  0);
        check("abort_conflicts", int'(conflicts), 0);
        check("abort_done",      int'(done),      0);
        check("abort_err",       int'(err_region), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_scan(0);

        // Start held high re-triggers a second scan.
        set_colors(2);
        sb_q.push_back(model());
        sb_q.push_back(model());
        @(negedge clk);
        start = 1'b1;
        i = 0;
        while (sb_q.size() > 1 && i < 2000) begin
            @(negedge clk);
            i++;
        end
        repeat (3) @(negedge clk);
        start = 1'b0;
        wait_empty();

        // Randomised maps: colours, stray neighbour numbers, emptied regions, stray starts.
        for (int k = 0; k < 6; k++) begin
            build_map();
            set_colors(2);
            if ($urandom_range(0, 2) == 0)
                mem[$urandom_range(0, 147)] = 8'($urandom_range(N, 255));
            if ($urandom_range(0, 2) == 0) begin
                i = $urandom_range(0, N - 2);
                mem[IDX+i] = mem[IDX+i+1];
            end
            run_scan(($urandom_range(0, 1) == 1) ? $urandom_range(1, 300) : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
